// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder: MMIO register
// offsets, CTRL/STATUS bit positions and the address-region decode enum.
package dmem_pkg;

    localparam logic [15:0] OFF_GPIO    = 16'h0000;
    localparam logic [15:0] OFF_COUNT   = 16'h0004;
    localparam logic [15:0] OFF_COMPARE = 16'h0008;
    localparam logic [15:0] OFF_CTRL    = 16'h000C;
    localparam logic [15:0] OFF_STATUS  = 16'h0010;

    localparam int unsigned CTRL_IRQ_EN   = 0;
    localparam int unsigned STAT_CMP_HIT  = 0;
    localparam int unsigned STAT_MISALIGN = 1;
    localparam int unsigned STAT_UNMAPPED = 2;
    localparam int unsigned STAT_W        = 3;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_UNMAPPED
    } region_e;

endpackage

// File: rtl/dmem_mmio_regs.sv
// Memory-mapped I/O bank: GPIO, free-running COUNT, COMPARE, CTRL and the
// write-1-to-clear STATUS register that drives the interrupt request.
module dmem_mmio_regs
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en_i,
    input  logic [15:0] offset_i,
    input  logic [31:0] wdata_i,
    input  logic        set_misalign_i,
    input  logic        set_unmapped_i,
    output logic [31:0] rdata_o,
    output logic [31:0] gpio_o,
    output logic        irq_o
);

    logic [31:0]       gpio_q, gpio_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       compare_q, compare_d;
    logic              ctrl_q, ctrl_d;
    logic [STAT_W-1:0] status_q, status_d;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        gpio_d    = gpio_q;
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        ctrl_d    = ctrl_q;
        status_d  = status_q;
        if (wr_en_i) begin
            case (offset_i)
                OFF_GPIO:    gpio_d    = wdata_i;
                OFF_COUNT:   count_d   = wdata_i;
                OFF_COMPARE: compare_d = wdata_i;
                OFF_CTRL:    ctrl_d    = wdata_i[CTRL_IRQ_EN];
                OFF_STATUS:  status_d  = status_q & ~wdata_i[STAT_W-1:0];
                default:     ;
            endcase
        end
        // Event sets are applied after the W1C so a same-cycle set wins.
        status_d[STAT_CMP_HIT]  = status_d[STAT_CMP_HIT]  | (count_q == compare_q);
        status_d[STAT_MISALIGN] = status_d[STAT_MISALIGN] | set_misalign_i;
        status_d[STAT_UNMAPPED] = status_d[STAT_UNMAPPED] | set_unmapped_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gpio_q    <= '0;
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            ctrl_q    <= 1'b0;
            status_q  <= '0;
        end else begin
            gpio_q    <= gpio_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (offset_i)
            OFF_GPIO:    rdata_o = gpio_q;
            OFF_COUNT:   rdata_o = count_q;
            OFF_COMPARE: rdata_o = compare_q;
            OFF_CTRL:    rdata_o = {31'd0, ctrl_q};
            OFF_STATUS:  rdata_o = {{(32 - STAT_W){1'b0}}, status_q};
            default:     rdata_o = '0;
        endcase
    end

    assign gpio_o = gpio_q;
    assign irq_o  = ctrl_q & status_q[STAT_CMP_HIT];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the MIPS Memory stage: word RAM plus MMIO bank.
// Define DMEM_FAULT_EN to fault (and suppress) misaligned/unmapped accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    output logic [31:0] DmmRD,
    output logic [31:0] GpioOut,
    output logic        Irq,
    output logic        Fault
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    region_e       region;
    logic          ram_sel;
    logic          misalign;
    logic          unmapped;
    logic [AW-1:0] ram_idx;
    logic [15:0]   mmio_offset;
    logic [31:0]   mmio_rdata;
    logic          mmio_wr;
    logic [31:0]   mem_q [DEPTH];

    always_comb begin
        if (ALUOutM[31:16] == MMIO_BASE[31:16]) begin
            region = REGION_MMIO;
        end else if (ALUOutM < RAM_BYTES) begin
            region = REGION_RAM;
        end else begin
            region = REGION_UNMAPPED;
        end
    end

`ifdef DMEM_FAULT_EN
    logic strobe;
    assign strobe   = MemWriteM | MemtoRegM;
    assign misalign = strobe & (ALUOutM[1:0] != 2'b00);
    assign unmapped = strobe & (region == REGION_UNMAPPED);
    assign ram_sel  = (region == REGION_RAM);
`else
    // Without fault checking the load strobe has no role; unmapped space aliases into RAM.
    logic unused_load_strobe;
    assign unused_load_strobe = MemtoRegM;
    assign misalign = 1'b0;
    assign unmapped = 1'b0;
    assign ram_sel  = (region != REGION_MMIO);
`endif

    assign Fault       = misalign | unmapped;
    assign ram_idx     = ALUOutM[AW+1:2];
    assign mmio_offset = {ALUOutM[15:2], 2'b00};
    assign mmio_wr     = MemWriteM & (region == REGION_MMIO) & ~Fault;

    // NOTE: the RAM array has no reset; contents survive reset and a store during reset still commits.
    always_ff @(posedge clk) begin
        if (MemWriteM && ram_sel && !Fault) begin
            mem_q[ram_idx] <= WriteDataM;
        end
    end

    dmem_mmio_regs u_mmio_regs (
        .clk            (clk),
        .rst_n          (reset),
        .wr_en_i        (mmio_wr),
        .offset_i       (mmio_offset),
        .wdata_i        (WriteDataM),
        .set_misalign_i (misalign),
        .set_unmapped_i (unmapped),
        .rdata_o        (mmio_rdata),
        .gpio_o         (GpioOut),
        .irq_o          (Irq)
    );

    always_comb begin
        DmmRD = '0;
        if (!Fault) begin
            if (region == REGION_MMIO) begin
                DmmRD = mmio_rdata;
            end else if (ram_sel) begin
                DmmRD = mem_q[ram_idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by
// random traffic, all checked against a behavioural model of the memory map.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] MMIO  = 32'hFFFF_0000;
`ifdef DMEM_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUOutM, WriteDataM;
    logic        MemWriteM, MemtoRegM;
    logic [31:0] DmmRD, GpioOut;
    logic        Irq, Fault;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .DmmRD      (DmmRD),
        .GpioOut    (GpioOut),
        .Irq        (Irq),
        .Fault      (Fault)
    );

    // Reference model state
    logic [31:0] m_ram [DEPTH];
    logic [31:0] m_gpio, m_count, m_compare, m_ctrl, m_status;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_is_mmio(input logic [31:0] a);
        return a[31:16] == MMIO[31:16];
    endfunction

    function automatic bit m_in_ram(input logic [31:0] a);
        return a < DEPTH * 4;
    endfunction

    function automatic bit m_misal(input logic [31:0] a, input bit strobe);
        return FAULT_EN && strobe && (a % 4 != 0);
    endfunction

    function automatic bit m_unm(input logic [31:0] a, input bit strobe);
        return FAULT_EN && strobe && !m_is_mmio(a) && !m_in_ram(a);
    endfunction

    function automatic logic [31:0] m_word_off(input logic [31:0] a);
        return (a % 65536) / 4 * 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input bit strobe);
        if (m_misal(a, strobe) || m_unm(a, strobe)) return 32'd0;
        if (m_is_mmio(a)) begin
            case (m_word_off(a))
                32'h00:  return m_gpio;
                32'h04:  return m_count;
                32'h08:  return m_compare;
                32'h0C:  return m_ctrl;
                32'h10:  return m_status;
                default: return 32'd0;
            endcase
        end
        if (m_in_ram(a) || !FAULT_EN) return m_ram[(a / 4) % DEPTH];
        return 32'd0;
    endfunction

    task automatic m_reset();
        m_gpio    = 32'd0;
        m_count   = 32'd0;
        m_compare = 32'hFFFF_FFFF;
        m_ctrl    = 32'd0;
        m_status  = 32'd0;
    endtask

    // One bus cycle: drive, check combinational outputs, then advance the model.
    task automatic step(input bit rst_n, input logic [31:0] a, input logic [31:0] wd,
                        input bit we, input bit re);
        bit          misal, unm, hit, flt;
        logic [31:0] next_count;
        @(negedge clk);
        reset      = rst_n;
        ALUOutM    = a;
        WriteDataM = wd;
        MemWriteM  = we;
        MemtoRegM  = re;
        #1;
        misal   = m_misal(a, we || re);
        unm     = m_unm(a, we || re);
        flt     = misal || unm;
        last_rd = DmmRD;
        check("DmmRD", DmmRD, m_load(a, we || re));
        check("Fault", 32'(Fault), 32'(flt));
        check("Irq", 32'(Irq), 32'(m_ctrl[0] && m_status[0]));
        check("GpioOut", GpioOut, m_gpio);
        @(posedge clk);
        hit = (m_count == m_compare);
        if (we && !flt && !m_is_mmio(a) && (m_in_ram(a) || !FAULT_EN))
            m_ram[(a / 4) % DEPTH] = wd;
        if (!rst_n) begin
            m_reset();
        end else begin
            next_count = m_count + 32'd1;
            if (we && !flt && m_is_mmio(a)) begin
                case (m_word_off(a))
                    32'h00: m_gpio    = wd;
                    32'h04: next_count = wd;
                    32'h08: m_compare = wd;
                    32'h0C: m_ctrl    = wd & 32'd1;
                    32'h10: m_status  = m_status & ~(wd & 32'd7);
                    default: ;
                endcase
            end
            m_count = next_count;
            if (hit)   m_status[0] = 1'b1;
            if (misal) m_status[1] = 1'b1;
            if (unm)   m_status[2] = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] a, wd, r;
        bit          we, re, rn;
        logic [31:0] offs [6];
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h40};

        reset = 1'b0; ALUOutM = '0; WriteDataM = '0; MemWriteM = 1'b0; MemtoRegM = 1'b0;
        m_reset();
        for (int i = 0; i < DEPTH; i++) m_ram[i] = 'x;

        // Reset state
        step(0, 32'd0, 32'd0, 0, 0);
        step(1, MMIO + 32'h08, 32'd0, 0, 1);
        check("rst_compare", last_rd, 32'hFFFF_FFFF);
        step(1, MMIO + 32'h10, 32'd0, 0, 1);
        check("rst_status", last_rd, 32'd0);

        for (int i = 0; i < DEPTH; i++) step(1, 32'(i * 4), $urandom(), 1, 0);

        // Store then load, read-during-write shows old value
        step(1, 32'h10, 32'hDEAD_BEEF, 1, 0);
        step(1, 32'h10, 32'd0, 0, 1);
        check("ram_rdback", last_rd, 32'hDEAD_BEEF);

        // COUNT load and wrap
        step(1, MMIO + 32'h04, 32'hFFFF_FFFE, 1, 0);
        step(1, MMIO + 32'h04, 32'd0, 0, 1);
        check("count_0", last_rd, 32'hFFFF_FFFE);
        step(1, MMIO + 32'h04, 32'd0, 0, 1);
        check("count_1", last_rd, 32'hFFFF_FFFF);
        step(1, MMIO + 32'h04, 32'd0, 0, 1);
        check("count_wrap", last_rd, 32'h0000_0000);

        // Compare interrupt
        step(1, MMIO + 32'h0C, 32'd1, 1, 0);
        step(1, MMIO + 32'h08, m_count + 32'd5, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 32'h0, 32'd0, 0, 0);
        check("irq_raised", 32'(Irq), 32'd1);
        step(1, MMIO + 32'h10, 32'd1, 1, 0);
        step(1, 32'h0, 32'd0, 0, 0);
        check("irq_w1c", 32'(Irq), 32'd0);
        step(1, MMIO + 32'h08, m_count + 32'd3, 1, 0);
        for (int i = 0; i < 3; i++) step(1, MMIO + 32'h10, 32'd1, 1, 0);
        step(1, 32'h0, 32'd0, 0, 0);
        check("irq_set_wins", 32'(Irq), 32'd1);

        // Reset mid-operation, with a store in flight
        step(1, MMIO + 32'h00, 32'hA5A5_A5A5, 1, 0);
        step(0, 32'h20, 32'h1234_5678, 1, 0);
        step(1, MMIO + 32'h08, 32'd0, 0, 1);
        check("rst_gpio", GpioOut, 32'd0);
        check("rst_compare2", last_rd, 32'hFFFF_FFFF);
        step(1, 32'h10, 32'd0, 0, 1);
        check("ram_keeps", last_rd, 32'hDEAD_BEEF);
        step(1, 32'h20, 32'd0, 0, 1);
        check("ram_store_in_rst", last_rd, 32'h1234_5678);

        // Misaligned and unmapped stores
        step(1, 32'h13, 32'h1111_1111, 1, 0);
        step(1, 32'h8000_0000, 32'h2222_2222, 1, 0);
        step(1, MMIO + 32'h10, 32'd0, 0, 1);
        check("fault_status", last_rd, FAULT_EN ? 32'h6 : 32'h0);
        step(1, 32'h10, 32'd0, 0, 1);
        check("fault_ram", last_rd, FAULT_EN ? 32'hDEAD_BEEF : 32'h1111_1111);

        // Unused MMIO offset
        step(1, MMIO + 32'h40, 32'hFFFF_FFFF, 1, 0);
        step(1, MMIO + 32'h40, 32'd0, 0, 1);
        check("mmio_hole", last_rd, 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
                4, 5, 6:    a = MMIO + offs[$urandom_range(0, 5)];
                7:          a = $urandom_range(0, DEPTH * 4 - 1);
                8: begin
                    r = $urandom();
                    r[31] = 1'b1;
                    if (r[31:16] == MMIO[31:16]) r[16] = 1'b0;
                    a = r;
                end
                default:    a = MMIO + 32'($urandom_range(0, 65535));
            endcase
            wd = $urandom();
            if (m_is_mmio(a) && m_word_off(a) == 32'h08) wd = m_count + 32'($urandom_range(0, 12));
            if (m_is_mmio(a) && m_word_off(a) == 32'h04 && $urandom_range(0, 3) == 0) wd = 32'hFFFF_FFFE;
            we = ($urandom_range(0, 2) == 0);
            re = !we && ($urandom_range(0, 1) == 0);
            rn = ($urandom_range(0, 63) != 0);
            step(rn, a, wd, we, re);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
